// File: rtl/pyc_stream_rr_arb.sv
// ---------------------------------------------------------------------------
// pyc_stream_rr_arb
//
// N-to-1 ready/valid stream arbiter with round-robin priority and an
// optional burst lock. The winner of an arbitration round may keep the
// grant for up to MAX_BURST consecutive beats. The output is a single
// registered pipe stage that still sustains one beat per cycle, because a
// new beat may load in the same cycle the consumer takes the current one.
//
// Parameters
//   N          number of requesters (>= 2)
//   WIDTH      data width per stream
//   MAX_BURST  max consecutive beats per grant tenure (>= 1, 1 = pure RR)
//   SRC_W      width of out_src (derived, min 1)
//
// Ports
//   clk        clock
//   rst_n      synchronous active-low reset
//   in_valid   [N]        per-requester valid
//   in_ready   [N]        per-requester ready (combinational, one-hot or 0)
//   in_data    [N*WIDTH]  requester i occupies bits [i*WIDTH +: WIDTH]
//   out_valid             registered output valid
//   out_ready             consumer ready
//   out_data   [WIDTH]    registered output data
//   out_src    [SRC_W]    index of the requester that produced out_data
// ---------------------------------------------------------------------------
module pyc_stream_rr_arb #(
  parameter  int N         = 4,
  parameter  int WIDTH     = 32,
  parameter  int MAX_BURST = 1,
  localparam int SRC_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SRC_W-1:0]   out_src
);

  // Burst counter holds 0..MAX_BURST.
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [SRC_W-1:0] LAST_ID   = SRC_W'(N - 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic [SRC_W-1:0]   r_out_src;
  logic [SRC_W-1:0]   r_rr_ptr;     // last requester whose tenure ended
  logic               r_lock_vld;
  logic [SRC_W-1:0]   r_lock_id;
  logic [CNT_W-1:0]   r_burst_cnt;  // beats taken in the current tenure

  // -------------------------------------------------------------------------
  // Combinational arbitration
  // -------------------------------------------------------------------------
  logic               w_load;
  logic               w_lock_hit;
  logic               w_rr_found;
  logic [SRC_W-1:0]   w_rr_gnt;
  logic               w_gnt_vld;
  logic [SRC_W-1:0]   w_gnt;
  logic [CNT_W-1:0]   w_cnt;
  logic [WIDTH-1:0]   w_gnt_data;

  // The pipe stage may accept whenever it is empty or being drained this
  // cycle; this is what keeps throughput at one beat per cycle.
  assign w_load     = !r_out_valid || out_ready;

  // A locked owner keeps priority only while it is still presenting data;
  // if it drops valid, arbitration falls straight through to round-robin.
  assign w_lock_hit = r_lock_vld && in_valid[r_lock_id];

  // Round-robin scan starting just after the last tenure owner.
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    idx        = 0;
    w_rr_found = 1'b0;
    w_rr_gnt   = '0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(r_rr_ptr) + off) % N;
      if (!w_rr_found && in_valid[idx]) begin
        w_rr_found = 1'b1;
        w_rr_gnt   = SRC_W'(idx);
      end
    end
  end

  assign w_gnt_vld = w_load && (w_lock_hit || w_rr_found);
  assign w_gnt     = w_lock_hit ? r_lock_id : w_rr_gnt;

  // Beat count of the tenure after this transfer: continuing the current
  // lock adds one, anything else starts a fresh tenure.
  assign w_cnt = (r_lock_vld && (r_lock_id == w_gnt)) ? (r_burst_cnt + 1'b1)
                                                     : CNT_W'(1);

  assign w_gnt_data = in_data[int'(w_gnt)*WIDTH +: WIDTH];

  // Ready is forced low during reset so nothing is consumed that the reset
  // is about to discard.
  always_comb begin
    in_ready = '0;
    if (rst_n && w_gnt_vld) begin
      in_ready[w_gnt] = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Sequential update
  // -------------------------------------------------------------------------
  // A grant always implies in_valid[gnt] && in_ready[gnt], so w_gnt_vld
  // doubles as the transfer strobe.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_rr_ptr    <= LAST_ID;  // requester 0 gets first priority
      r_lock_vld  <= 1'b0;
      r_lock_id   <= '0;
      r_burst_cnt <= '0;
    end else if (w_load) begin
      if (w_gnt_vld) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gnt_data;
        r_out_src   <= w_gnt;
        if (w_cnt == BURST_MAX) begin
          // Tenure complete: release the lock and rotate priority.
          r_lock_vld  <= 1'b0;
          r_burst_cnt <= '0;
          r_rr_ptr    <= w_gnt;
        end else begin
          r_lock_vld  <= 1'b1;
          r_lock_id   <= w_gnt;
          r_burst_cnt <= w_cnt;
        end
      end else begin
        r_out_valid <= 1'b0;
        // Owner went idle with nobody else requesting: end its tenure so it
        // rotates to the back of the queue like a completed burst.
        if (r_lock_vld && !in_valid[r_lock_id]) begin
          r_lock_vld  <= 1'b0;
          r_burst_cnt <= '0;
          r_rr_ptr    <= r_lock_id;
        end
      end
    end
    // load=0: the consumer is stalling a full stage, everything holds.
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

endmodule

// File: doc/pyc_stream_rr_arb.md
Name: pyc_stream_rr_arb

Overview:
- N-to-1 ready/valid stream arbiter. Shares one downstream consumer between N producers using round-robin priority.
- Optional burst lock: a winner keeps the grant for up to MAX_BURST consecutive beats.
- Output is a registered pipe stage with full throughput. Sits in front of shared resources such as memory ports and shared FIFOs.
- Uses flat in_valid/in_ready/in_data ports, matching the existing primitives.

Parameters:
N, 4, number of requesters (>=2)
WIDTH, 32, data width per stream
MAX_BURST, 1, max consecutive beats per grant tenure (>=1; 1 = pure round-robin)
SRC_W, $clog2(N), width of out_src (localparam, min 1)

Ports:
clk  input  1  clock
rst_n  input  1  reset; one clock; reset is synchronous and active-low
in_valid  input  N  per-requester valid
in_ready  output  N  per-requester ready (combinational)
in_data  input  N*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH]
out_valid  output  1  registered output valid
out_ready  input  1  consumer ready
out_data  output  WIDTH  registered output data
out_src  output  SRC_W  index of requester that produced out_data

Behaviour:
- State:
  - out_valid, out_data, out_src.
  - rr_ptr: last requester whose tenure ended.
  - lock_vld, lock_id.
  - burst_cnt: beats taken in the current tenure, range 0..MAX_BURST.
- Reset (rst_n=0 at posedge):
  - out_valid=0, out_data=0, out_src=0.
  - rr_ptr=N-1, so requester 0 has first priority.
  - lock_vld=0, lock_id=0, burst_cnt=0.
  - in_ready=0 for all i while rst_n=0 (combinationally gated).
- load = !out_valid || out_ready. This gives full throughput: one beat per cycle when out_ready is held high.
- Grant (combinational, only when load=1):
  - If lock_vld && in_valid[lock_id]: gnt=lock_id.
  - Else: first i with in_valid[i]=1, scanning rr_ptr+1, rr_ptr+2, ... mod N.
  - None valid: no grant.
  - A locked owner that drops valid loses the lock in that same cycle. Arbitration falls through to round-robin from rr_ptr.
- in_ready[i] = rst_n && load && grant valid && gnt==i. At most one in_ready is high.
- Transfer at posedge when in_valid[gnt] && in_ready[gnt]:
  - out_data<=in_data[gnt], out_src<=gnt, out_valid<=1.
  - Tenure count: cnt = (lock_vld && lock_id==gnt) ? burst_cnt+1 : 1.
  - If cnt==MAX_BURST: lock_vld<=0, burst_cnt<=0, rr_ptr<=gnt.
  - Else: lock_vld<=1, lock_id<=gnt, burst_cnt<=cnt.
- No transfer, load=1: out_valid<=0.
  - If lock_vld and the owner is not valid, then lock_vld<=0, burst_cnt<=0, rr_ptr<=lock_id.
- load=0 (out_valid && !out_ready):
  - All output and arbitration state holds.
  - out_data/out_src stable while stalled.
  - No in_ready asserted.
- Producers must hold valid/data until accepted. The arbiter never drops or duplicates a beat.
- Fairness: with all N valid continuously, out_ready=1 and MAX_BURST=B, the grant sequence is 0 xB, 1 xB, ..., N-1 xB, 0 xB, ...
- Latency: a beat accepted at edge k appears on out_* after edge k (1 cycle).
- Reset mid-operation:
  - Pending output beat is discarded and lock cleared.
  - Priority restarts at 0 on the first cycle after rst_n returns high.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all in_valid=1 -> in_ready=0000, out_valid=0. First accepted beat after release is from src 0.
- Pure round-robin: N=4, MAX_BURST=1, all valid, out_ready=1, data=0x100+i -> out_src sequence 0,1,2,3,0,1 with one beat per cycle; out_data matches source.
- Burst lock: MAX_BURST=3, requesters 1 and 2 valid -> out_src 1,1,1,2,2,2,1. Requester 1 drops valid after 2 beats -> grant moves to 2 in that same cycle; 1 resumes only after 2's tenure.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_src stable, all in_ready=0, no source beat consumed. out_ready=1 -> next beat the following cycle, no loss or duplicate (scoreboard per source).
- Sparse/skip: only requester 3 valid, rr_ptr=0 -> grant 3 immediately. Requester 0 then asserts valid -> wins next (wrap-around past N-1).
- Random: 10k cycles with random valids, random out_ready and MAX_BURST in {1,2,4} -> per-source in-order delivery, one in_ready max, no beat lost. No requester is starved beyond (N-1)*MAX_BURST granted beats while continuously valid.
